// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte buffer and pacing stage in front of uart_tx. A producer pushes bytes
//   at clk rate into a circular FIFO. One byte is popped per UART frame. Its
//   value is presented on tx_data together with a one-clk tx_start pulse. The
//   block then waits FRAME_TICKS+GUARD_TICKS rising edges of clk_uart before it
//   may pop the next byte.
//
// Parameters
//   ADDR_W       FIFO address width, depth = 2**ADDR_W bytes
//   FRAME_TICKS  clk_uart rising edges per frame (start + 8 data + stop)
//   GUARD_TICKS  extra idle clk_uart rising edges between frames
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   clk_uart  in   baud clock level, synchronous to clk
//   wr_en     in   push request
//   wr_data   in   byte to push
//   full      out  FIFO holds 2**ADDR_W bytes
//   empty     out  FIFO holds no bytes
//   count     out  number of bytes stored (ADDR_W+1 bits)
//   tx_start  out  one-clk start pulse towards uart_tx
//   tx_data   out  byte towards uart_tx, held until the next pop
//
// Optional feature: define UART_TX_FIFO_OVF_EN to add the sticky overflow
// flag. The flag adds input ovf_clr and output ovf. ovf sets on a push into
// a full FIFO. A set in the same cycle as ovf_clr takes priority over the clear.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int ADDR_W      = 4,
    parameter int FRAME_TICKS = 10,
    parameter int GUARD_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_uart,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [7:0]        tx_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TOTAL = FRAME_TICKS + GUARD_TICKS;
    localparam int TW    = $clog2(TOTAL) + 1;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TOTAL - 1);
    localparam logic [TW-1:0]   TICK_ONE  = TW'(1);
    localparam logic [TW-1:0]   TICK_ZERO = TW'(0);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_ZERO  = (ADDR_W + 1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic [7:0]      mem_r [DEPTH];
    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic [ADDR_W:0] wr_ptr_next_s;
    logic [ADDR_W:0] rd_ptr_next_s;
    logic [ADDR_W:0] count_r;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            clk_uart_q_r;
    logic            tick_s;
    state_t          state_r;
    state_t          state_next_s;
    logic [TW-1:0]   tick_cnt_r;
    logic [TW-1:0]   tick_cnt_next_s;
    logic            tx_start_r;
    logic [7:0]      tx_data_r;

    // The extra wrap bit on the pointers tells full apart from empty when the
    // address bits match.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                     (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);

    // A push is judged against the registered full flag. A pop in the same
    // cycle therefore never makes room for that push.
    assign push_s        = wr_en & ~full_s;
    assign wr_ptr_next_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    assign rd_ptr_next_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

    // A baud tick is one clk wide and marks a rising edge of clk_uart.
    assign tick_s = clk_uart & ~clk_uart_q_r;

    // FIFO storage write port (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    // FIFO pointers and registered fill count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= PTR_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= wr_ptr_next_s - rd_ptr_next_s;
        end
    end

    // Pacing FSM next-state logic, pop decision and frame tick counting
    always_comb begin
        state_next_s    = state_r;
        tick_cnt_next_s = tick_cnt_r;
        pop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_next_s    = ST_LOAD;
                    pop_s           = 1'b1;
                    tick_cnt_next_s = TICK_ZERO;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick_s) begin
                    if (tick_cnt_r == TICK_LAST) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_next_s = tick_cnt_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pacing FSM state, baud edge history and registered uart_tx outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            tick_cnt_r   <= TICK_ZERO;
            clk_uart_q_r <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
        end else begin
            state_r      <= state_next_s;
            tick_cnt_r   <= tick_cnt_next_s;
            clk_uart_q_r <= clk_uart;
            // tx_start is high exactly while the FSM sits in LOAD.
            tx_start_r   <= (state_next_s == ST_LOAD);
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r[ADDR_W-1:0]];
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_r;

    // Sticky overflow flag; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (wr_en && full_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int ADDR_W = 4;
    localparam int FT     = 10;
    localparam int GT     = 1;
    localparam int FRAME  = FT + GT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clk_uart;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              tx_start;
    logic [7:0]        tx_data;
`ifdef UART_TX_FIFO_OVF_EN
    logic              ovf_clr;
    logic              ovf;
`endif

    uart_tx_fifo #(
        .ADDR_W      (ADDR_W),
        .FRAME_TICKS (FT),
        .GUARD_TICKS (GT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_uart (clk_uart),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_start (tx_start),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0]      data;
        bit              accept;
        logic [ADDR_W:0] exp_count;
        bit              exp_full;
        bit              exp_empty;
    } vec_t;
    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // baud clock: period 4 clk, changed on falling clk edges, can be frozen low
    bit         baud_on = 1'b1;
    logic [1:0] div;
    initial begin
        div      = 2'd0;
        clk_uart = 1'b0;
        forever begin
            @(negedge clk);
            div      = div + 2'd1;
            clk_uart = baud_on & div[1];
        end
    end

    // monitor: scoreboard pop on tx_start, tx_data hold, frame spacing in baud ticks
    bit         uart_prev;
    bit         bt;
    bit         last_bt;
    bit         prev_bt;
    bit         armed;
    bit         frame_end;
    int         edges_since;
    int         wait_ticks;
    int         wt_before;
    logic [7:0] last_tx;
    logic [7:0] exp_b;
    initial begin
        uart_prev   = 1'b0;
        last_bt     = 1'b0;
        armed       = 1'b0;
        frame_end   = 1'b0;
        edges_since = 0;
        wait_ticks  = 0;
        last_tx     = 8'h00;
        forever begin
            @(posedge clk);
            bt          = clk_uart & ~uart_prev;
            uart_prev   = clk_uart;
            wt_before   = wait_ticks;
            prev_bt     = last_bt;
            edges_since = edges_since + 1;
            frame_end   = (edges_since >= 2) && bt && (wait_ticks == FRAME - 1);
            if (edges_since >= 2 && bt) wait_ticks = wait_ticks + 1;
            last_bt     = bt;
            #1;
            if (!rst_n) begin
                armed   = 1'b0;
                last_tx = 8'h00;
                check("tx_data_in_reset", tx_data, 32'h0);
                check("tx_start_in_reset", tx_start, 32'h0);
            end else if (tx_start) begin
                if (armed) begin
                    check("frame_ticks", wt_before, FRAME);
                    check("frame_end_on_tick", prev_bt, 32'h1);
                end
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: tx_start with data %02h, expected no frame", tx_data);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("tx_data_order", tx_data, exp_b);
                end
                last_tx     = tx_data;
                armed       = 1'b1;
                edges_since = 0;
                wait_ticks  = 0;
            end else begin
                check("tx_data_hold", tx_data, last_tx);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            sb_q.push_back(first + 8'(i));
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", sb_q.size(), 32'h0);
        repeat (64) @(posedge clk);
    endtask

    bit found;

    initial begin
        for (int i = 0; i < 17; i++) begin
            vecs[i].data      = 8'h20 + 8'(i);
            vecs[i].accept    = (i < 16);
            vecs[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].exp_full  = (i >= 15);
            vecs[i].exp_empty = 1'b0;
        end

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            check("idle_tx_start", tx_start, 32'h0);
        end
        check("rst_empty", empty, 32'h1);
        check("rst_full", full, 32'h0);
        check("rst_count", count, 32'h0);
        check("rst_tx_data", tx_data, 32'h0);

        // 2: single push latency, then a second byte paced one frame later
        armed = 1'b0;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        sb_q.push_back(8'hA5);
        @(posedge clk);
        #2;
        check("push_count", count, 32'h1);
        check("push_empty", empty, 32'h0);
        check("push_no_start_yet", tx_start, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        check("latency_tx_start", tx_start, 32'h1);
        check("latency_tx_data", tx_data, 32'hA5);
        check("pop_count", count, 32'h0);
        check("pop_empty", empty, 32'h1);
        push_burst(8'hB7, 1);
        drain();

        // 3: three back-to-back bytes
        armed = 1'b0;
        push_burst(8'h01, 3);
        drain();

        // 4: transmitter stalled, fill to full and overflow
        baud_on = 1'b0;
        repeat (8) @(negedge clk);
        armed = 1'b0;
        push_burst(8'h10, 1);
        repeat (4) @(posedge clk);
        #2;
        check("stall_count", count, 32'h0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = vecs[i].data;
            if (vecs[i].accept) sb_q.push_back(vecs[i].data);
            @(posedge clk);
            #2;
            check($sformatf("fill_count[%0d]", i), count, vecs[i].exp_count);
            check($sformatf("fill_full[%0d]", i), full, vecs[i].exp_full);
            check($sformatf("fill_empty[%0d]", i), empty, vecs[i].exp_empty);
        end
        @(negedge clk);
        wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set", ovf, 32'h1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #2;
        check("ovf_cleared", ovf, 32'h0);
        @(negedge clk);
        ovf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("full_hold_count", count, 32'd16);
        baud_on = 1'b1;
        drain();

        // 5: push coinciding with the pop at count 5
        armed = 1'b0;
        push_burst(8'h40, 6);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk);
            #2;
            if (frame_end) found = 1'b1;
        end
        check("frame_end_seen", found, 32'h1);
        check("count_before_pushpop", count, 32'h5);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        sb_q.push_back(8'h77);
        @(posedge clk);
        #2;
        check("pushpop_count", count, 32'h5);
        check("pushpop_tx_start", tx_start, 32'h1);
        check("pushpop_tx_data", tx_data, 32'h41);
        @(negedge clk);
        wr_en = 1'b0;
        drain();

        // 6: reset in the middle of a frame
        armed = 1'b0;
        push_burst(8'h5A, 3);
        repeat (12) @(posedge clk);
        #2;
        check("pre_reset_count", count, 32'h2);
        check("pre_reset_tx_data", tx_data, 32'h5A);
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_tx_start", tx_start, 32'h0);
        check("midrst_tx_data", tx_data, 32'h0);
        check("midrst_count", count, 32'h0);
        check("midrst_empty", empty, 32'h1);
        check("midrst_full", full, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        sb_q.push_back(8'h3C);
        @(posedge clk);
        #2;
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        check("post_rst_tx_start", tx_start, 32'h1);
        check("post_rst_tx_data", tx_data, 32'h3C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
